// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha stream-side logic.
// Holds block/word geometry, the default round count, the controller state
// encoding and a helper that selects one keystream word out of a block.
package chacha_pkg;

   localparam int unsigned CHACHA_BLOCK_W  = 512;
   localparam int unsigned CHACHA_WORD_W   = 32;
   localparam int unsigned WORDS_PER_BLOCK = 16;
   localparam int unsigned WIDX_W          = 4;
   localparam int unsigned KEY_W           = 256;
   localparam int unsigned NONCE_W         = 64;
   localparam logic [4:0]  ROUNDS_20       = 5'h14;

   localparam int unsigned STATE_W    = 3;
   localparam logic [2:0]  ST_IDLE    = 3'd0;
   localparam logic [2:0]  ST_INIT    = 3'd1;
   localparam logic [2:0]  ST_WAIT_KS = 3'd2;
   localparam logic [2:0]  ST_STREAM  = 3'd3;
   localparam logic [2:0]  ST_NEXT    = 3'd4;
   localparam logic [2:0]  ST_DRAIN   = 3'd5;

   // Word 0 of a block sits in the most significant 32 bits.
   function automatic logic [CHACHA_WORD_W-1:0] ks_word(
      input logic [WORDS_PER_BLOCK-1:0][CHACHA_WORD_W-1:0] blk,
      input logic [WIDX_W-1:0]                             idx
   );
      return blk[4'(WORDS_PER_BLOCK - 1) - idx];
   endfunction

endpackage

// File: rtl/chacha_xor_skid.sv
// Output register stage: XORs an accepted input word with the current
// keystream word and holds the result until downstream takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  input side may accept words (controller in STREAM)
//   in_valid/in_ready   input handshake; in_data/in_last payload
//   ks_word             keystream word for the word being accepted
//   in_fire             input handshake happens this cycle
//   out_valid/out_ready output handshake; out_data/out_last payload
module chacha_xor_skid
   import chacha_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CHACHA_WORD_W-1:0] in_data,
   input  logic                     in_last,
   input  logic [CHACHA_WORD_W-1:0] ks_word,
   output logic                     in_fire,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CHACHA_WORD_W-1:0] out_data,
   output logic                     out_last
);

   logic                     out_valid_q;
   logic [CHACHA_WORD_W-1:0] out_data_q;
   logic                     out_last_q;

   // Accept when the register is empty or is being emptied this cycle.
   assign in_ready  = en && (!out_valid_q || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (in_fire) begin
         out_valid_q <= 1'b1;
         out_data_q  <= in_data ^ ks_word;
         out_last_q  <= in_last;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/chacha_stream_xor.sv
// Stream-side controller for an external chacha_core. Drives the core's
// init/next handshake, captures each 512-bit keystream block and XORs it
// word by word onto a 32-bit valid/ready stream (encrypt == decrypt).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, key, iv, ctr         begin a message; key/iv/ctr sampled on start
//   busy, done, block_count     message status
//   in_valid/in_ready/in_data/in_last       input word stream
//   out_valid/out_ready/out_data/out_last   output word stream
//   core_*                      connection to chacha_core
module chacha_stream_xor
   import chacha_pkg::*;
#(
   parameter logic [4:0] ROUNDS = ROUNDS_20,
   parameter logic       KEYLEN = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [KEY_W-1:0]          key,
   input  logic [NONCE_W-1:0]        iv,
   input  logic [NONCE_W-1:0]        ctr,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               block_count,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHACHA_WORD_W-1:0]  in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHACHA_WORD_W-1:0]  out_data,
   output logic                      out_last,
   output logic                      core_init,
   output logic                      core_next,
   output logic [KEY_W-1:0]          core_key,
   output logic [NONCE_W-1:0]        core_iv,
   output logic [NONCE_W-1:0]        core_ctr,
   output logic                      core_keylen,
   output logic [4:0]                core_rounds,
   input  logic                      core_ready,
   input  logic [CHACHA_BLOCK_W-1:0] core_data_out,
   input  logic                      core_data_out_valid
);

   logic [STATE_W-1:0]                            state_q, state_d;
   logic [KEY_W-1:0]                              key_q, key_d;
   logic [NONCE_W-1:0]                            iv_q, iv_d;
   logic [NONCE_W-1:0]                            ctr_q, ctr_d;
   logic [WORDS_PER_BLOCK-1:0][CHACHA_WORD_W-1:0] ks_buf_q, ks_buf_d;
   logic [WIDX_W-1:0]                             widx_q, widx_d;
   logic [31:0]                                   block_count_q, block_count_d;
   logic                                          busy_q, busy_d;
   logic                                          done_q, done_d;
   logic                                          core_init_q, core_init_d;
   logic                                          core_next_q, core_next_d;

   logic                     stream_en;
   logic                     in_fire;
   logic [CHACHA_WORD_W-1:0] cur_ks;

   assign stream_en = (state_q == ST_STREAM);
   assign cur_ks    = ks_word(ks_buf_q, widx_q);

   chacha_xor_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .en        (stream_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .ks_word   (cur_ks),
      .in_fire   (in_fire),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      iv_d          = iv_q;
      ctr_d         = ctr_q;
      ks_buf_d      = ks_buf_q;
      widx_d        = widx_q;
      block_count_d = block_count_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      core_init_d   = 1'b0;
      core_next_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d         = key;
               iv_d          = iv;
               ctr_d         = ctr;
               block_count_d = '0;
               busy_d        = 1'b1;
               state_d       = ST_INIT;
            end
         end
         ST_INIT: begin
            if (core_ready) begin
               core_init_d = 1'b1;
               state_d     = ST_WAIT_KS;
            end
         end
         ST_NEXT: begin
            if (core_ready) begin
               core_next_d = 1'b1;
               state_d     = ST_WAIT_KS;
            end
         end
         ST_WAIT_KS: begin
            // While the init/next pulse is on the wire the core still shows
            // the previous block as valid; skip that cycle.
            if (core_data_out_valid && core_ready && !core_init_q && !core_next_q) begin
               ks_buf_d      = core_data_out;
               widx_d        = '0;
               block_count_d = block_count_q + 32'd1;
               state_d       = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (in_fire) begin
               widx_d = widx_q + 4'd1;
               if (in_last) begin
                  state_d = ST_DRAIN;
               end else if (widx_q == 4'(WORDS_PER_BLOCK - 1)) begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_DRAIN: begin
            // The output register holds only the final word here.
            if (out_valid && out_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         key_q         <= '0;
         iv_q          <= '0;
         ctr_q         <= '0;
         ks_buf_q      <= '0;
         widx_q        <= '0;
         block_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         core_init_q   <= 1'b0;
         core_next_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         iv_q          <= iv_d;
         ctr_q         <= ctr_d;
         ks_buf_q      <= ks_buf_d;
         widx_q        <= widx_d;
         block_count_q <= block_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         core_init_q   <= core_init_d;
         core_next_q   <= core_next_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign block_count = block_count_q;
   assign core_init   = core_init_q;
   assign core_next   = core_next_q;
   assign core_key    = key_q;
   assign core_iv     = iv_q;
   assign core_ctr    = ctr_q;
   assign core_keylen = KEYLEN;
   assign core_rounds = ROUNDS;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor with a behavioural chacha_core model and a
// ChaCha20 reference computed directly from the block function.
module tb_chacha_stream_xor;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [63:0]  iv = '0;
   logic [63:0]  ctr = '0;
   logic         busy, done;
   logic [31:0]  block_count;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         out_last;
   logic         core_init, core_next;
   logic [255:0] core_key;
   logic [63:0]  core_iv, core_ctr;
   logic         core_keylen;
   logic [4:0]   core_rounds;
   logic         core_ready = 1'b1;
   logic [511:0] core_data_out = '0;
   logic         core_data_out_valid = 1'b0;

   always #5 clk = ~clk;

   chacha_stream_xor #(.ROUNDS(5'h14), .KEYLEN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .ctr(ctr),
      .busy(busy), .done(done), .block_count(block_count),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_init(core_init), .core_next(core_next), .core_key(core_key), .core_iv(core_iv),
      .core_ctr(core_ctr), .core_keylen(core_keylen), .core_rounds(core_rounds),
      .core_ready(core_ready), .core_data_out(core_data_out),
      .core_data_out_valid(core_data_out_valid)
   );

   // ---------------- ChaCha20 reference ----------------
   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
      logic [31:0] a, b, c, d;
      a = a0; b = b0; c = c0; d = d0;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // Keystream bytes in stream order, first byte in bits [511:504].
   function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [63:0] n,
                                                 input logic [63:0] c);
      logic [31:0]  s [16];
      logic [31:0]  x [16];
      logic [511:0] r;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = bswap(k[255 - 32 * i -: 32]);
      s[12] = c[31:0];
      s[13] = c[63:32];
      s[14] = bswap(n[63:32]);
      s[15] = bswap(n[31:0]);
      for (int i = 0; i < 16; i++) x[i] = s[i];
      for (int dr = 0; dr < 10; dr++) begin
         {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) r[511 - 32 * i -: 32] = bswap(x[i] + s[i]);
      return r;
   endfunction

   // Keystream word number i of a message (block i/16, word i%16).
   function automatic logic [31:0] ref_ks(input logic [255:0] k, input logic [63:0] n,
                                          input logic [63:0] c, input int i);
      logic [511:0] blk;
      blk = chacha_block(k, n, c + 64'(i / 16));
      return blk[511 - 32 * (i % 16) -: 32];
   endfunction

   // ---------------- chacha_core behavioural model ----------------
   int          n_init = 0;
   int          n_next = 0;
   int          cm_cnt = 0;
   logic [63:0] cm_ctr = '0;

   always @(posedge clk) begin
      if (core_init || core_next) begin
         if (core_init) begin
            cm_ctr <= core_ctr;
            n_init <= n_init + 1;
         end else begin
            cm_ctr <= cm_ctr + 64'd1;
            n_next <= n_next + 1;
         end
         cm_cnt              <= int'($urandom_range(1, 5));
         core_ready          <= 1'b0;
         core_data_out_valid <= 1'b0;
      end else if (cm_cnt > 0) begin
         cm_cnt <= cm_cnt - 1;
         if (cm_cnt == 1) begin
            core_data_out       <= chacha_block(core_key, core_iv, cm_ctr);
            core_ready          <= 1'b1;
            core_data_out_valid <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [31:0] pt_q[$];
   logic [31:0] out_q[$];
   logic        last_q[$];
   int          done_cnt;
   int          stab_err;

   // Drives pt_q into the DUT and collects the output stream. Optional
   // backpressure, early abort after abort_at accepted words, and a stray
   // start pulse while the message is in flight.
   task automatic run_msg(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c,
                          input bit bp, input int abort_at, input bit poke_start);
      int          acc = 0;
      int          post = 0;
      int          cyc = 0;
      logic        held_v = 1'b0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      out_q.delete();
      last_q.delete();
      done_cnt = 0;
      stab_err = 0;
      @(negedge clk);
      key = k; iv = n; ctr = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 chk("busy_after_start", busy, 1);
      while (cyc < 4000 && post < 4) begin
         @(negedge clk);
         if (abort_at >= 0 && acc == abort_at) begin
            in_valid = 1'b0;
            return;
         end
         start = poke_start && (cyc == 3);
         if (acc < pt_q.size()) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = pt_q[acc];
            in_last  = (acc == pt_q.size() - 1);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (done) done_cnt++;
         if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l)) stab_err++;
         if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         held_l = out_last;
         if (in_valid && in_ready) acc++;
         if (done_cnt > 0) post++;
         cyc++;
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      chk("msg_finished_in_budget", (post >= 4), 1);
   endtask

   task automatic check_msg(input string tag, input logic [255:0] k, input logic [63:0] n,
                            input logic [63:0] c, input int i0, input int n0);
      int          nw = pt_q.size();
      int          nb = (nw + 15) / 16;
      logic [31:0] got;
      logic        gl;
      chk($sformatf("%s_count", tag), out_q.size(), nw);
      for (int i = 0; i < nw; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 'x;
         gl  = (i < last_q.size()) ? last_q[i] : 1'bx;
         chk($sformatf("%s_w%0d", tag, i), got, pt_q[i] ^ ref_ks(k, n, c, i));
         chk($sformatf("%s_last%0d", tag, i), gl, (i == nw - 1));
      end
      chk($sformatf("%s_block_count", tag), block_count, nb);
      chk($sformatf("%s_inits", tag), n_init - i0, 1);
      chk($sformatf("%s_nexts", tag), n_next - n0, nb - 1);
      chk($sformatf("%s_done_once", tag), done_cnt, 1);
      chk($sformatf("%s_stable", tag), stab_err, 0);
      chk($sformatf("%s_idle", tag), busy, 0);
   endtask

   initial begin
      logic [255:0] k;
      logic [63:0]  n, c;
      logic [31:0]  orig[$];
      int           i0, n0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_block_count", block_count, 0);
      chk("rst_core_init", core_init, 0);
      chk("rst_core_next", core_next, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_ctr", core_ctr, 0);
      chk("core_rounds", core_rounds, 5'h14);
      chk("core_keylen", core_keylen, 1);
      @(negedge clk);
      rst = 1'b0;

      // Zero-key RFC vector, one block
      pt_q.delete();
      repeat (16) pt_q.push_back(32'h0);
      i0 = n_init; n0 = n_next;
      run_msg('0, '0, '0, 1'b0, -1, 1'b0);
      check_msg("zero", '0, '0, '0, i0, n0);
      chk("zero_rfc_w0", (out_q.size() > 0) ? out_q[0] : 32'hx, 32'h76b8e0ad);

      // Three-block message with a stray start while busy
      k = {4{64'h0123456789abcdef}};
      n = 64'hdeadbeefcafebabe;
      pt_q.delete();
      repeat (40) pt_q.push_back($urandom);
      i0 = n_init; n0 = n_next;
      run_msg(k, n, '0, 1'b0, -1, 1'b1);
      check_msg("multi", k, n, '0, i0, n0);

      // Random backpressure, counter crossing the 32-bit boundary
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom};
      c = 64'h0000_0000_ffff_ffff;
      pt_q.delete();
      repeat (37) pt_q.push_back($urandom);
      i0 = n_init; n0 = n_next;
      run_msg(k, n, c, 1'b1, -1, 1'b0);
      check_msg("bp", k, n, c, i0, n0);

      // Round trip: decrypting the ciphertext recovers the plaintext
      c = {$urandom, $urandom};
      orig.delete();
      pt_q.delete();
      repeat (21) begin
         orig.push_back($urandom);
         pt_q.push_back(orig[$]);
      end
      run_msg(k, n, c, 1'b1, -1, 1'b0);
      pt_q = out_q;
      run_msg(k, n, c, 1'b1, -1, 1'b0);
      chk("rt_count", out_q.size(), orig.size());
      for (int i = 0; i < orig.size(); i++)
         chk($sformatf("rt_w%0d", i), (i < out_q.size()) ? out_q[i] : 32'hx, orig[i]);

      // Short message: no next, following message starts with a fresh init
      pt_q.delete();
      repeat (4) pt_q.push_back($urandom);
      i0 = n_init; n0 = n_next;
      run_msg(k, n, c, 1'b0, -1, 1'b0);
      check_msg("short", k, n, c, i0, n0);

      // Reset in STREAM at widx=7, then block 0 is reproduced from word 0
      pt_q.delete();
      repeat (20) pt_q.push_back($urandom);
      run_msg(k, n, c, 1'b0, 7, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_core_init", core_init, 0);
      chk("midrst_core_next", core_next, 0);
      chk("midrst_block_count", block_count, 0);
      @(negedge clk);
      rst = 1'b0;
      pt_q.delete();
      repeat (16) pt_q.push_back($urandom);
      i0 = n_init; n0 = n_next;
      run_msg(k, n, c, 1'b0, -1, 1'b0);
      check_msg("after_rst", k, n, c, i0, n0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
